// File: rtl/write_data_buffer_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_data_buffer_responder_pkg
// Description : Shared types, constants and parity helpers for the PSL
//               buffer-read responder (write-data line store).
// Revision    : 1.0 - initial release
// ============================================================================
package write_data_buffer_responder_pkg;

  // Read latency advertised to the PSL on ah_brlat (legal: 1 or 3).
  localparam int WRITE_DATA_BRLAT = 1;

  localparam int TAG_W  = 8;
  localparam int LINE_W = 512;
  localparam int LANES  = 8;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
  } WriteCmd;

  // One 64B half-line deposited by a compute unit.
  typedef struct packed {
    logic              valid;
    WriteCmd           cmd;
    logic [LINE_W-1:0] data;
  } ReadWriteDataLine;

  // Tag retired by the response path.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } TagRelease;

  // PSL buffer-read request (ha_br*).
  typedef struct packed {
    logic             read_valid;
    logic [TAG_W-1:0] read_tag;
    logic             read_tag_parity;
    logic [5:0]       read_address;
  } WriteDataControlInterface;

  // Sticky read errors; bit 0 = tag parity, bit 1 = unwritten half.
  typedef struct packed {
    logic unwritten;
    logic tag_parity;
  } WriteDataReadError;

  function automatic logic odd_parity64(input logic [63:0] d);
    return ~^d;
  endfunction

  function automatic logic odd_parity8(input logic [TAG_W-1:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/write_data_buffer_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : write_data_buffer_responder_if
// Description : PSL buffer-read bus: request (ha_br*) and response (ah_br*).
// Revision    : 1.0 - initial release
// ============================================================================
interface write_data_buffer_responder_if;
  import write_data_buffer_responder_pkg::*;

  WriteDataControlInterface buffer_in;
  logic [3:0]               ah_brlat;
  logic [LINE_W-1:0]        ah_brdata;
  logic [LANES-1:0]         ah_brpar;

  // PSL side: issues reads, samples data at the advertised latency.
  modport master (
    output buffer_in,
    input  ah_brlat,
    input  ah_brdata,
    input  ah_brpar
  );

  // AFU side: the responder.
  modport slave (
    input  buffer_in,
    output ah_brlat,
    output ah_brdata,
    output ah_brpar
  );
endinterface
`default_nettype wire

// File: rtl/write_data_buffer_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : write_data_ram
// Description : Simple dual-port line store, read-first, one registered read
//               port. Storage itself is never reset; only the read register.
// Revision    : 1.0 - initial release
// ============================================================================
module write_data_ram #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 512
) (
  input  wire logic              clock,
  input  wire logic              rstn,
  input  wire logic              we_i,
  input  wire logic [ADDR_W-1:0] waddr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  input  wire logic              re_i,
  input  wire logic [ADDR_W-1:0] raddr_i,
  output logic      [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write; no reset so the array maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; sampling before the same-edge write gives old data on collision.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/write_data_buffer_responder.sv
`default_nettype none
// ============================================================================
// Module      : write_data_buffer_responder
// Description : Answers PSL buffer-read requests from a tag-indexed store of
//               half-lines, at fixed latency BRLAT, with per-lane odd parity
//               and sticky tag-parity / unwritten-half error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module write_data_buffer_responder
  import write_data_buffer_responder_pkg::*;
#(
  parameter int BRLAT     = WRITE_DATA_BRLAT,
  parameter int TAG_COUNT = 256
) (
  input  wire logic                   clock,
  input  wire logic                   rstn,
  input  wire logic                   enabled_in,
  input  wire ReadWriteDataLine       wr_line_in,
  input  wire logic                   wr_half_in,
  input  wire TagRelease              tag_release_in,
  write_data_buffer_responder_if.slave br,
  output logic [1:0]                  data_read_error
);

  localparam int TAG_BITS = $clog2(TAG_COUNT);
  localparam int IDX_W    = TAG_BITS + 1;
  localparam int DEPTH    = 2 * TAG_COUNT;

  logic [DEPTH-1:0]  hv_q, hv_d;
  WriteDataReadError err_q, err_d;
  logic              loaded_q;

  logic              accept;
  logic [IDX_W-1:0]  rd_idx, wr_idx, rel_idx0, rel_idx1;
  logic [LINE_W-1:0] ram_rdata;
  logic [LINE_W-1:0] out_data;
  logic              out_load;
  logic [LANES-1:0]  brpar;
  logic              unused_ok;

  assign accept   = br.buffer_in.read_valid && enabled_in;
  // Address bit 5 selects the 64B half; the low address bits carry no meaning here.
  assign rd_idx   = {br.buffer_in.read_tag[TAG_BITS-1:0], br.buffer_in.read_address[5]};
  assign wr_idx   = {wr_line_in.cmd.tag[TAG_BITS-1:0], wr_half_in};
  assign rel_idx0 = {tag_release_in.tag[TAG_BITS-1:0], 1'b0};
  assign rel_idx1 = {tag_release_in.tag[TAG_BITS-1:0], 1'b1};
  assign unused_ok = ^{br.buffer_in.read_address[4:0], br.buffer_in.read_tag,
                       wr_line_in.cmd.tag, tag_release_in.tag};

  write_data_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W),
    .DATA_W (LINE_W)
  ) u_ram (
    .clock   (clock),
    .rstn    (rstn),
    .we_i    (wr_line_in.valid),
    .waddr_i (wr_idx),
    .wdata_i (wr_line_in.data),
    .re_i    (accept),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  // Half-valid update: release first so a same-cycle write to the tag wins.
  always_comb begin
    hv_d = hv_q;
    if (tag_release_in.valid) begin
      hv_d[rel_idx0] = 1'b0;
      hv_d[rel_idx1] = 1'b0;
    end
    if (wr_line_in.valid) begin
      hv_d[wr_idx] = 1'b1;
    end
  end

  // Sticky error accumulation, judged against half-valid state before this cycle's writes.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      if (br.buffer_in.read_tag_parity != odd_parity8(br.buffer_in.read_tag)) begin
        err_d.tag_parity = 1'b1;
      end
      if (!hv_q[rd_idx]) begin
        err_d.unwritten = 1'b1;
      end
    end
  end

  // Control state: half-valids, errors, and whether the output ever held read data.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      hv_q     <= '0;
      err_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      hv_q  <= hv_d;
      err_q <= err_d;
      if (out_load) begin
        loaded_q <= 1'b1;
      end
    end
  end

  // Latency 1 uses the RAM read register as the output; any other value builds
  // the 3-cycle pipeline (two extra stages behind the RAM register).
  if (BRLAT == 1) begin : g_lat1
    assign out_data = ram_rdata;
    assign out_load = accept;
  end else begin : g_lat3
    logic              s1_vld_q, s2_vld_q;
    logic [LINE_W-1:0] s2_data_q, s3_data_q;

    // Streaming stages; data registers only move with a valid so the output holds between reads.
    always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
        s1_vld_q  <= 1'b0;
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
        s3_data_q <= '0;
      end else begin
        s1_vld_q <= accept;
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_data_q <= ram_rdata;
        end
        if (s2_vld_q) begin
          s3_data_q <= s2_data_q;
        end
      end
    end

    assign out_data = s3_data_q;
    assign out_load = s2_vld_q;
  end

  // Parity derived from the driven data itself; forced to 0 until data has been loaded.
  always_comb begin
    brpar = '0;
    if (loaded_q) begin
      for (int i = 0; i < LANES; i++) begin
        brpar[i] = odd_parity64(out_data[64*i +: 64]);
      end
    end
  end

  assign br.ah_brlat      = 4'(BRLAT);
  assign br.ah_brdata     = out_data;
  assign br.ah_brpar      = brpar;
  assign data_read_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_write_data_buffer_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_data_buffer_responder
// Description : Drives identical traffic into a BRLAT=1 and a BRLAT=3 responder
//               and checks both against a line-store reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_data_buffer_responder;
  import write_data_buffer_responder_pkg::*;

  typedef struct {
    int          due;
    logic [511:0] data;
    bit          known;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             enabled;
  ReadWriteDataLine wr_line;
  logic             wr_half;
  TagRelease        tag_rel;
  logic [1:0]       err1, err3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model
  logic [511:0] m_mem [512];
  bit           m_hv [512];
  bit           m_known [512];
  logic [1:0]   exp_err = 2'b00;
  exp_t         sbq0[$];
  exp_t         sbq1[$];
  bit           lastv [2];
  bit           lastk [2];
  logic [511:0] lastd [2];

  write_data_buffer_responder_if bus1 ();
  write_data_buffer_responder_if bus3 ();

  write_data_buffer_responder #(.BRLAT(1), .TAG_COUNT(256)) u_dut1 (
    .clock(clk), .rstn(rstn), .enabled_in(enabled), .wr_line_in(wr_line),
    .wr_half_in(wr_half), .tag_release_in(tag_rel), .br(bus1), .data_read_error(err1)
  );

  write_data_buffer_responder #(.BRLAT(3), .TAG_COUNT(256)) u_dut3 (
    .clock(clk), .rstn(rstn), .enabled_in(enabled), .wr_line_in(wr_line),
    .wr_half_in(wr_half), .tag_release_in(tag_rel), .br(bus3), .data_read_error(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_par(input logic [511:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = ~^d[64*i +: 64];
    return r;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    sbq0.delete();
    sbq1.delete();
    for (int i = 0; i < 512; i++) m_hv[i] = 1'b0;
    exp_err = 2'b00;
    for (int k = 0; k < 2; k++) begin
      lastv[k] = 1'b0;
      lastk[k] = 1'b1;
      lastd[k] = '0;
    end
  endtask

  // pop the due entry (if any) for one DUT and compare, otherwise check the hold value
  task automatic check_out(input int k, input logic [511:0] d, input logic [7:0] p);
    exp_t e;
    bit   have = 1'b0;
    if (k == 0) begin
      if (sbq0.size() > 0 && sbq0[0].due <= cyc) begin e = sbq0.pop_front(); have = 1'b1; end
    end else begin
      if (sbq1.size() > 0 && sbq1[0].due <= cyc) begin e = sbq1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      cmp(k == 0 ? "due_cycle_lat1" : "due_cycle_lat3", 512'(cyc), 512'(e.due));
      lastv[k] = 1'b1;
      lastk[k] = e.known;
      if (e.known) begin
        lastd[k] = e.data;
        cmp(k == 0 ? "rdata_lat1" : "rdata_lat3", d, e.data);
        cmp(k == 0 ? "rpar_lat1" : "rpar_lat3", 512'(p), 512'(exp_par(e.data)));
      end else begin
        cmp(k == 0 ? "rpar_unk_lat1" : "rpar_unk_lat3", 512'(p), 512'(exp_par(d)));
      end
    end else if (lastk[k]) begin
      cmp(k == 0 ? "hold_lat1" : "hold_lat3", d, lastd[k]);
      cmp(k == 0 ? "holdpar_lat1" : "holdpar_lat3", 512'(p),
          512'(lastv[k] ? exp_par(lastd[k]) : 8'h00));
    end
  endtask

  // monitor: sampled on the falling edge, decoupled from stimulus
  always @(negedge clk) begin
    if (rstn) begin
      check_out(0, bus1.ah_brdata, bus1.ah_brpar);
      check_out(1, bus3.ah_brdata, bus3.ah_brpar);
      cmp("err_lat1", 512'(err1), 512'(exp_err));
      cmp("err_lat3", 512'(err3), 512'(exp_err));
    end
  end

  // one clock of stimulus; the expected response is computed and queued here
  task automatic step(input bit rd, input bit [7:0] rtag, input bit rhalf, input bit badpar,
                      input bit en, input bit wr, input bit [7:0] wtag, input bit whalf,
                      input logic [511:0] wdata, input bit rel, input bit [7:0] reltag);
    int         p;
    int         idx;
    exp_t       e;
    logic [1:0] nerr;
    logic [5:0] addr;
    addr[5]   = rhalf;
    addr[4:0] = 5'($urandom_range(0, 31));
    p = cyc + 1;
    bus1.buffer_in.read_valid      = rd;
    bus1.buffer_in.read_tag        = rtag;
    bus1.buffer_in.read_tag_parity = badpar ? ^rtag : ~^rtag;
    bus1.buffer_in.read_address    = addr;
    bus3.buffer_in                 = bus1.buffer_in;
    enabled        = en;
    wr_line.valid  = wr;
    wr_line.cmd.tag = wtag;
    wr_line.data   = wdata;
    wr_half        = whalf;
    tag_rel.valid  = rel;
    tag_rel.tag    = reltag;
    nerr = exp_err;
    if (rd && en) begin
      idx = {23'd0, rtag, rhalf};
      if (badpar) nerr[0] = 1'b1;
      if (!m_hv[idx]) nerr[1] = 1'b1;
      e.data  = m_mem[idx];
      e.known = m_known[idx];
      e.due   = p;
      sbq0.push_back(e);
      e.due   = p + 2;
      sbq1.push_back(e);
    end
    if (rel) begin
      m_hv[{23'd0, reltag, 1'b0}] = 1'b0;
      m_hv[{23'd0, reltag, 1'b1}] = 1'b0;
    end
    if (wr) begin
      idx = {23'd0, wtag, whalf};
      m_mem[idx]   = wdata;
      m_hv[idx]    = 1'b1;
      m_known[idx] = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_err = nerr;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, '0, 0, 8'h00);
  endtask

  task automatic rd_req(input bit [7:0] tag, input bit half, input bit badpar);
    step(1, tag, half, badpar, 1, 0, 8'h00, 0, '0, 0, 8'h00);
  endtask

  task automatic wr_req(input bit [7:0] tag, input bit half, input logic [511:0] d);
    step(0, 8'h00, 0, 0, 1, 1, tag, half, d, 0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tagname);
    cmp({tagname, "_data1"}, bus1.ah_brdata, '0);
    cmp({tagname, "_data3"}, bus3.ah_brdata, '0);
    cmp({tagname, "_par1"}, 512'(bus1.ah_brpar), '0);
    cmp({tagname, "_par3"}, 512'(bus3.ah_brpar), '0);
    cmp({tagname, "_err1"}, 512'(err1), '0);
    cmp({tagname, "_err3"}, 512'(err3), '0);
    cmp({tagname, "_brlat1"}, 512'(bus1.ah_brlat), 512'(1));
    cmp({tagname, "_brlat3"}, 512'(bus3.ah_brlat), 512'(3));
  endtask

  logic [511:0] line_a, line_b, line_c;

  initial begin
    for (int i = 0; i < 512; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    model_reset();
    enabled = 1'b1;
    wr_line = '0;
    wr_half = 1'b0;
    tag_rel = '0;
    bus1.buffer_in = '0;
    bus3.buffer_in = '0;
    line_a = rand_line();
    line_b = rand_line();
    line_c = rand_line();

    // power-on reset
    #2 rstn = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    // fill tag 0x05 and 0x07, then back-to-back reads of both halves of 0x05
    wr_req(8'h05, 0, line_a);
    wr_req(8'h05, 1, line_b);
    wr_req(8'h07, 0, rand_line());
    wr_req(8'h07, 1, rand_line());
    rd_req(8'h05, 0, 0);
    rd_req(8'h05, 1, 0);
    repeat (4) idle();

    // disabled read is dropped
    step(1, 8'h07, 0, 1, 0, 0, 8'h00, 0, '0, 0, 8'h00);
    repeat (3) idle();

    // bad tag parity on a written tag
    rd_req(8'h07, 0, 1);
    repeat (4) idle();

    // release then read: unwritten flagged, data still the last written
    step(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, '0, 1, 8'h05);
    rd_req(8'h05, 1, 0);
    repeat (4) idle();

    // same-cycle write and read of one index returns old data, then new
    step(1, 8'h05, 1, 0, 1, 1, 8'h05, 1, line_c, 0, 8'h00);
    rd_req(8'h05, 1, 0);
    repeat (4) idle();

    // asynchronous reset with two reads in flight
    rd_req(8'h05, 0, 0);
    rd_req(8'h05, 1, 0);
    #2 rstn = 1'b0;
    model_reset();
    #1 check_reset_outputs("midrst");
    wr_line.valid = 1'b0;
    tag_rel.valid = 1'b0;
    bus1.buffer_in.read_valid = 1'b0;
    bus3.buffer_in.read_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) idle();

    // randomized traffic over a small tag range to force hits and collisions
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 8, 8'($urandom_range(0, 15)), 1'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 5, 8'($urandom_range(0, 15)), 1'($urandom), rand_line(),
           $urandom_range(0, 19) == 0, 8'($urandom_range(0, 15)));
    end
    repeat (6) idle();

    cmp("drain_lat1", 512'(sbq0.size()), '0);
    cmp("drain_lat3", 512'(sbq1.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
